uart_port: RTL and testbench
============================

Name: uart_port

Overview:
- Parametrised single-channel UART: TX/RX FIFOs, runtime baud divisor, parity and stop-bit modes, sticky error flags, maskable level interrupt.
- Successor to the fixed 8-channel serial endpoints behind the AXI register slave.
- Instantiated once per pin pair.
- Register front-end drives the cfg_* and stream ports; tx_pin/rx_pin go to the Pmod headers.

Parameters:
- DATA_BITS, 8: payload bits per frame; legal values 5..9.
- FIFO_DEPTH, 16: entries in each of the TX and RX FIFOs; must be a power of 2, at least 2.
- DIV_W, 16: width of the baud divisor.
- OVS, 16: oversample ticks per bit; must be even, at least 4.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- cfg_div  in  DIV_W  oversample tick every cfg_div+1 clk cycles.
- cfg_parity  in  2  0 = none, 1 = even, 2 = odd, 3 = reserved (treated as none).
- cfg_stop2  in  1  1 = two stop bits.
- cfg_irq_en  in  3  [0] RX not empty, [1] TX FIFO empty, [2] any sticky error.
- tx_data  in  DATA_BITS  TX payload.
- tx_valid  in  1  TX push request.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  DATA_BITS  RX FIFO head.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  RX pop.
- err_clr  in  1  clears all sticky errors.
- err_parity  out  1  sticky parity error.
- err_frame  out  1  sticky framing error.
- err_overrun  out  1  sticky overrun error.
- tx_count  out  $clog2(FIFO_DEPTH+1)  TX FIFO occupancy.
- rx_count  out  $clog2(FIFO_DEPTH+1)  RX FIFO occupancy.
- tx_busy  out  1  shifter active.
- irq  out  1  registered level interrupt.
- tx_pin  out  1  serial out, idles high.
- rx_pin  in  1  serial in, asynchronous to clk.

Behaviour:
- Reset values:
  - tx_pin = 1.
  - tx_busy, rx_valid, irq = 0; all err_* = 0; both counts = 0.
  - tx_ready = 1.
  - Both FSMs in IDLE, tick counter = 0.
  - Reset mid-frame aborts the frame; tx_pin is high the cycle after reset is sampled.
- Tick generator:
  - Free-running down-counter reloaded with cfg_div; emits a one-cycle tick at 0.
  - cfg_div = 0 gives a tick every cycle.
  - One bit time = OVS ticks.
- Stream handshakes:
  - TX push when tx_valid & tx_ready.
  - RX pop when rx_valid & rx_ready.
  - Push and pop in the same cycle are both honoured and the count is unchanged.
  - Push into a full TX FIFO is ignored.
  - rx_data is valid combinationally whenever rx_valid = 1.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped when parity is none) -> STOP -> IDLE.
  - IDLE pops the FIFO when it is non-empty, latches cfg_parity, cfg_stop2 and the payload, and aligns to the next tick.
  - Each state holds tx_pin for OVS ticks. Data goes out LSB first.
  - Parity bit = XOR of the data bits for even parity, inverted for odd.
  - STOP lasts 1 or 2 bit times.
  - Back-to-back frames have no extra idle time.
  - cfg changes mid-frame take effect at the next frame.
- RX path:
  - rx_pin passes through a 2-flop synchroniser.
  - IDLE detects a high-to-low transition, then counts OVS/2 ticks.
  - If the line is high at that midpoint, the start bit is a glitch: return to IDLE, push nothing.
  - Otherwise sample every OVS ticks: DATA_BITS data bits, the optional parity bit, then one stop bit. RX checks only the first stop bit, even when cfg_stop2 = 1.
  - On the stop sample:
    - Stop bit = 0 sets err_frame; the byte is still pushed.
    - Parity mismatch sets err_parity; the byte is still pushed.
    - RX FIFO full (after any same-cycle pop) drops the byte and sets err_overrun.
  - If stop = 0, RX waits for the line to return high before re-arming IDLE.
- Sticky errors:
  - Cleared by err_clr.
  - A set and err_clr in the same cycle leaves the flag set.
- irq, registered (one cycle of latency):
  - irq = (rx_valid & en[0]) | (tx_count == 0 & !tx_busy & en[1]) | ((err_parity | err_frame | err_overrun) & en[2]).
- Counts and pointers:
  - Counts are exact 0..FIFO_DEPTH.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

Decomposition:
- Package uart_pkg holds:
  - parity enum PAR_NONE/EVEN/ODD;
  - TX and RX state enums;
  - IRQ enable bit index constants.
- Sub-module sync_fifo (WIDTH, DEPTH), instantiated twice. Interface: push/pop/full/empty/count, registered storage, show-ahead read.

Test Plan:
- TX framing: cfg_div=0, no parity, 1 stop; push 0x55 -> tx_pin low 16 cycles, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, high at cycle 144; tx_busy drops after 160 cycles.
- Loopback: tx_pin to rx_pin, cfg_div=3, even parity, 2 stop; push 0x00, 0x07, 0xFF, 0xA5 -> same 4 bytes out of RX, no error flags; parity bit for 0x07 is 1.
- Framing error: drive a frame for 0x3C with stop = 0 -> 0x3C pushed, err_frame = 1, irq = 1 next cycle with en = 3'b100; err_clr -> err_frame = 0.
- Overrun: send 17 frames with rx_ready = 0, FIFO_DEPTH = 16 -> rx_count = 16, err_overrun = 1, head byte is the first frame.
- Glitch reject: rx_pin low for 4 cycles with cfg_div=0 -> no push, RX back in IDLE; a valid frame immediately after is received correctly.
- Reset mid-frame: assert reset during DATA of a TX frame -> tx_pin = 1 next cycle, tx_count = 0, tx_ready = 1, no residual bits afterwards.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- shared encodings for the uart_port block.
//   parity_t      : cfg_parity encoding (value 3 is reserved and behaves as none)
//   TX_* / RX_*   : FSM state codes
//   IRQ_*         : bit positions inside cfg_irq_en
//   par_on()      : true when a parity mode actually adds a parity bit
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_t;

   // TX state encoding
   localparam logic [2:0] TX_IDLE   = 3'd0;
   localparam logic [2:0] TX_START  = 3'd1;
   localparam logic [2:0] TX_DATA   = 3'd2;
   localparam logic [2:0] TX_PARITY = 3'd3;
   localparam logic [2:0] TX_STOP   = 3'd4;

   // RX state encoding; RX_WAIT holds off after a framing error until the line idles high
   localparam logic [2:0] RX_IDLE   = 3'd0;
   localparam logic [2:0] RX_START  = 3'd1;
   localparam logic [2:0] RX_DATA   = 3'd2;
   localparam logic [2:0] RX_PARITY = 3'd3;
   localparam logic [2:0] RX_STOP   = 3'd4;
   localparam logic [2:0] RX_WAIT   = 3'd5;

   localparam int IRQ_RX_NE    = 0;
   localparam int IRQ_TX_EMPTY = 1;
   localparam int IRQ_ERR      = 2;

   function automatic logic par_on(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_port_fifo.sv
// sync_fifo -- single-clock FIFO with show-ahead read.
//   push/push_data : write when not full, or when full with a same-cycle pop
//   pop/pop_data   : pop_data is the head, valid whenever empty = 0
//   full/empty     : occupancy flags
//   count          : exact occupancy 0..DEPTH
// Pointers are $clog2(DEPTH) bits and wrap naturally (DEPTH is a power of 2).
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             pop_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push & ~do_pop)      count <= count + 1'b1;
         else if (do_pop & ~do_push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/uart_port.sv
// uart_port -- single-channel UART with TX/RX FIFOs.
//   clk, reset            : single clock, synchronous active-high reset
//   cfg_div               : oversample tick every cfg_div+1 clocks; OVS ticks per bit
//   cfg_parity, cfg_stop2 : frame format (latched at the start of each frame)
//   cfg_irq_en            : [0] RX not empty, [1] TX idle and empty, [2] any sticky error
//   tx_data/valid/ready   : TX push stream
//   rx_data/valid/ready   : RX pop stream, rx_data is the show-ahead FIFO head
//   err_clr, err_*        : sticky error flags and their clear
//   tx_count, rx_count    : FIFO occupancy
//   tx_busy               : TX shifter active
//   irq                   : registered level interrupt
//   tx_pin, rx_pin        : serial line (rx_pin is asynchronous)
module uart_port import uart_pkg::*; #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16,
   parameter int OVS        = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [DIV_W-1:0]                  cfg_div,
   input  logic [1:0]                        cfg_parity,
   input  logic                              cfg_stop2,
   input  logic [2:0]                        cfg_irq_en,
   input  logic [DATA_BITS-1:0]              tx_data,
   input  logic                              tx_valid,
   output logic                              tx_ready,
   output logic [DATA_BITS-1:0]              rx_data,
   output logic                              rx_valid,
   input  logic                              rx_ready,
   input  logic                              err_clr,
   output logic                              err_parity,
   output logic                              err_frame,
   output logic                              err_overrun,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   tx_count,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_count,
   output logic                              tx_busy,
   output logic                              irq,
   output logic                              tx_pin,
   input  logic                              rx_pin
);
   localparam int TW = $clog2(OVS);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] T_LAST = TW'(OVS-1);
   localparam logic [TW-1:0] T_HALF = TW'(OVS/2-1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS-1);

   // ---------------- oversample tick ----------------
   logic [DIV_W-1:0] div_cnt;
   logic             tick;

   assign tick = (div_cnt == '0);

   always_ff @(posedge clk) begin
      if (reset)     div_cnt <= '0;
      else if (tick) div_cnt <= cfg_div;
      else           div_cnt <= div_cnt - 1'b1;
   end

   // ---------------- TX ----------------
   logic                 tx_full, tx_empty, tx_pop;
   logic [DATA_BITS-1:0] tx_head, tx_shift;
   logic [2:0]           tx_state;
   logic [TW-1:0]        tx_tcnt;
   logic [BW-1:0]        tx_bit;
   logic                 tx_par_en, tx_par_bit, tx_stop2, tx_stop_n;
   logic                 tx_last, tx_frame_end;

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk, .reset,
      .push(tx_valid & tx_ready), .push_data(tx_data),
      .pop(tx_pop), .pop_data(tx_head),
      .full(tx_full), .empty(tx_empty), .count(tx_count)
   );

   assign tx_ready     = ~tx_full;
   assign tx_busy      = (tx_state != TX_IDLE);
   assign tx_last      = (tx_tcnt == T_LAST);
   assign tx_frame_end = (tx_state == TX_STOP) & tx_last & (~tx_stop2 | tx_stop_n);
   // Loading straight from the end of STOP keeps back-to-back frames gap-free.
   assign tx_pop       = tick & ~tx_empty & ((tx_state == TX_IDLE) | tx_frame_end);

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state   <= TX_IDLE;
         tx_pin     <= 1'b1;
         tx_tcnt    <= '0;
         tx_bit     <= '0;
         tx_shift   <= '0;
         tx_par_en  <= 1'b0;
         tx_par_bit <= 1'b0;
         tx_stop2   <= 1'b0;
         tx_stop_n  <= 1'b0;
      end else if (tick) begin
         tx_tcnt <= (tx_state == TX_IDLE || tx_last) ? '0 : tx_tcnt + 1'b1;
         if (tx_pop) begin
            tx_state   <= TX_START;
            tx_pin     <= 1'b0;
            tx_shift   <= tx_head;
            tx_bit     <= '0;
            tx_stop_n  <= 1'b0;
            tx_par_en  <= par_on(cfg_parity);
            tx_par_bit <= (^tx_head) ^ (cfg_parity == PAR_ODD);
            tx_stop2   <= cfg_stop2;
         end else if (tx_last) begin
            case (tx_state)
               TX_IDLE: ;
               TX_START: begin
                  tx_state <= TX_DATA;
                  tx_pin   <= tx_shift[0];
               end
               TX_DATA: begin
                  if (tx_bit == B_LAST) begin
                     tx_state <= tx_par_en ? TX_PARITY : TX_STOP;
                     tx_pin   <= tx_par_en ? tx_par_bit : 1'b1;
                  end else begin
                     tx_bit   <= tx_bit + 1'b1;
                     tx_shift <= tx_shift >> 1;
                     tx_pin   <= tx_shift[1];
                  end
               end
               TX_PARITY: begin
                  tx_state <= TX_STOP;
                  tx_pin   <= 1'b1;
               end
               TX_STOP: begin
                  if (tx_frame_end) tx_state  <= TX_IDLE;
                  else              tx_stop_n <= 1'b1;
                  tx_pin <= 1'b1;
               end
               default: begin
                  tx_state <= TX_IDLE;
                  tx_pin   <= 1'b1;
               end
            endcase
         end
      end
   end

   // ---------------- RX ----------------
   logic                 rx_s1, rx_s2, rx_prev;
   logic [2:0]           rx_state;
   logic [TW-1:0]        rx_tcnt;
   logic [BW-1:0]        rx_bit;
   logic [DATA_BITS-1:0] rx_shift;
   logic                 rx_par_en, rx_odd, rx_par_bit;
   logic                 rx_full, rx_empty, rx_pop, rx_push;
   logic                 rx_stop_ev, rx_par_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx_pin;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   assign rx_stop_ev = tick & (rx_state == RX_STOP) & (rx_tcnt == T_LAST);
   assign rx_par_err = rx_par_en & (rx_par_bit != ((^rx_shift) ^ rx_odd));
   assign rx_valid   = ~rx_empty;
   assign rx_pop     = rx_valid & rx_ready;
   // A same-cycle pop frees the slot, so a full FIFO only overruns without one.
   assign rx_push    = rx_stop_ev & (~rx_full | rx_pop);

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk, .reset,
      .push(rx_push), .push_data(rx_shift),
      .pop(rx_pop), .pop_data(rx_data),
      .full(rx_full), .empty(rx_empty), .count(rx_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state   <= RX_IDLE;
         rx_tcnt    <= '0;
         rx_bit     <= '0;
         rx_shift   <= '0;
         rx_par_en  <= 1'b0;
         rx_odd     <= 1'b0;
         rx_par_bit <= 1'b0;
      end else begin
         case (rx_state)
            RX_IDLE: if (rx_prev & ~rx_s2) begin
               rx_state  <= RX_START;
               rx_tcnt   <= '0;
               rx_par_en <= par_on(cfg_parity);
               rx_odd    <= (cfg_parity == PAR_ODD);
            end
            RX_START: if (tick) begin
               if (rx_tcnt == T_HALF) begin
                  // line back high at mid start bit: treat as a glitch
                  rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                  rx_tcnt  <= '0;
                  rx_bit   <= '0;
               end else rx_tcnt <= rx_tcnt + 1'b1;
            end
            RX_DATA: if (tick) begin
               if (rx_tcnt == T_LAST) begin
                  rx_tcnt  <= '0;
                  rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                  rx_bit   <= rx_bit + 1'b1;
                  if (rx_bit == B_LAST) rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
               end else rx_tcnt <= rx_tcnt + 1'b1;
            end
            RX_PARITY: if (tick) begin
               if (rx_tcnt == T_LAST) begin
                  rx_tcnt    <= '0;
                  rx_par_bit <= rx_s2;
                  rx_state   <= RX_STOP;
               end else rx_tcnt <= rx_tcnt + 1'b1;
            end
            RX_STOP: if (tick) begin
               if (rx_tcnt == T_LAST) begin
                  rx_tcnt  <= '0;
                  rx_state <= rx_s2 ? RX_IDLE : RX_WAIT;
               end else rx_tcnt <= rx_tcnt + 1'b1;
            end
            RX_WAIT: if (rx_s2) rx_state <= RX_IDLE;
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // ---------------- sticky errors and irq ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         err_parity  <= 1'b0;
         err_frame   <= 1'b0;
         err_overrun <= 1'b0;
         irq         <= 1'b0;
      end else begin
         // a set wins over a same-cycle clear
         if (rx_stop_ev & rx_par_err)          err_parity  <= 1'b1;
         else if (err_clr)                     err_parity  <= 1'b0;
         if (rx_stop_ev & ~rx_s2)              err_frame   <= 1'b1;
         else if (err_clr)                     err_frame   <= 1'b0;
         if (rx_stop_ev & rx_full & ~rx_pop)   err_overrun <= 1'b1;
         else if (err_clr)                     err_overrun <= 1'b0;
         irq <= (rx_valid & cfg_irq_en[IRQ_RX_NE])
              | ((tx_count == '0) & ~tx_busy & cfg_irq_en[IRQ_TX_EMPTY])
              | ((err_parity | err_frame | err_overrun) & cfg_irq_en[IRQ_ERR]);
      end
   end

endmodule

// File: tb/tb_uart_port.sv
// tb_uart_port -- directed self-checking bench for uart_port (8 data bits, depth 16, OVS 16).
// Each task drives one scenario and checks its own hand-computed expectations.
module tb_uart_port;
   localparam int DATA_BITS  = 8;
   localparam int FIFO_DEPTH = 16;
   localparam int DIV_W      = 16;
   localparam int OVS        = 16;
   localparam int CW         = $clog2(FIFO_DEPTH+1);

   logic                 clk = 1'b0;
   logic                 reset;
   logic [DIV_W-1:0]     cfg_div;
   logic [1:0]           cfg_parity;
   logic                 cfg_stop2;
   logic [2:0]           cfg_irq_en;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid, tx_ready;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid, rx_ready;
   logic                 err_clr, err_parity, err_frame, err_overrun;
   logic [CW-1:0]        tx_count, rx_count;
   logic                 tx_busy, irq, tx_pin, rx_pin;
   logic                 rx_drv, loop_en;

   int errors = 0;
   int checks = 0;

   assign rx_pin = loop_en ? tx_pin : rx_drv;

   always #5 clk = ~clk;

   uart_port #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W), .OVS(OVS)) dut (
      .clk(clk), .reset(reset), .cfg_div(cfg_div), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
      .cfg_irq_en(cfg_irq_en), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .err_clr(err_clr),
      .err_parity(err_parity), .err_frame(err_frame), .err_overrun(err_overrun),
      .tx_count(tx_count), .rx_count(rx_count), .tx_busy(tx_busy), .irq(irq),
      .tx_pin(tx_pin), .rx_pin(rx_pin)
   );

   // ---------- stimulus helpers ----------
   task automatic do_reset();
      @(negedge clk); reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic push_byte(input logic [7:0] d);
      @(negedge clk); tx_data = d; tx_valid = 1'b1;
      @(negedge clk); tx_valid = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
   endtask

   // returns at the first negedge where tx_pin is low (t = 0 of the frame)
   task automatic wait_tx_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (tx_pin == 1'b0) begin ok = 1'b1; break; end
      end
   endtask

   // drives one frame on rx_pin at 16 clocks per bit (cfg_div = 0); par < 0 means no parity bit
   task automatic send_frame(input logic [7:0] d, input int par, input logic stp);
      @(negedge clk); rx_drv = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         repeat (16) @(negedge clk);
      end
      if (par >= 0) begin
         rx_drv = par[0];
         repeat (16) @(negedge clk);
      end
      rx_drv = stp;
      repeat (16) @(negedge clk);
      rx_drv = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   // ---------- scenarios ----------
   task automatic test_reset();
      reset = 1'b1; cfg_div = 16'hFFFF; cfg_parity = 2'd0; cfg_stop2 = 1'b0; cfg_irq_en = 3'b010;
      tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (tx_pin !== 1'b1) begin errors++; $display("FAIL rst_tx_pin: got %b want 1", tx_pin); end
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_tx_busy: got %b want 0", tx_busy); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
      checks++; if ({err_parity, err_frame, err_overrun} !== 3'b000) begin errors++;
         $display("FAIL rst_err: got %b want 000", {err_parity, err_frame, err_overrun}); end
      checks++; if (tx_count !== 5'd0 || rx_count !== 5'd0) begin errors++;
         $display("FAIL rst_counts: got tx=%0d rx=%0d want 0 0", tx_count, rx_count); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_empty: got %b want 1", irq); end
   endtask

   // runs right after test_reset: cfg_div = 0xFFFF means no second tick, so nothing is popped
   task automatic test_tx_fifo_full();
      for (int i = 0; i < 17; i++) begin
         @(negedge clk); tx_valid = 1'b1; tx_data = 8'(i);
      end
      @(negedge clk); tx_valid = 1'b0;
      checks++; if (tx_count !== 5'd16) begin errors++; $display("FAIL txf_count: got %0d want 16", tx_count); end
      checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL txf_ready: got %b want 0", tx_ready); end
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL txf_busy: got %b want 0", tx_busy); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL txf_irq: got %b want 0", irq); end
      cfg_div = 16'd0; cfg_irq_en = 3'b000;
      do_reset();
      checks++; if (tx_count !== 5'd0) begin errors++; $display("FAIL txf_after_rst: got %0d want 0", tx_count); end
   endtask

   task automatic test_tx_frame();
      logic [7:0] v;
      bit ok;
      v = 8'h55;
      push_byte(v);
      wait_tx_start(ok);
      checks++; if (!ok) begin errors++; $display("FAIL txfr_start: got timeout want start bit"); end
      repeat (8) @(negedge clk);
      checks++; if (tx_pin !== 1'b0) begin errors++; $display("FAIL txfr_startbit: got %b want 0", tx_pin); end
      for (int k = 0; k < 8; k++) begin
         repeat (16) @(negedge clk);
         checks++; if (tx_pin !== v[k]) begin errors++; $display("FAIL txfr_bit%0d: got %b want %b", k, tx_pin, v[k]); end
      end
      repeat (16) @(negedge clk);
      checks++; if (tx_pin !== 1'b1) begin errors++; $display("FAIL txfr_stop: got %b want 1", tx_pin); end
      repeat (7) @(negedge clk);
      checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL txfr_busy159: got %b want 1", tx_busy); end
      @(negedge clk);
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL txfr_busy160: got %b want 0", tx_busy); end
   endtask

   // 0x07 has three ones: even parity bit 1, odd parity bit 0
   task automatic test_tx_parity();
      bit ok;
      logic want;
      for (int m = 1; m <= 2; m++) begin
         cfg_parity = 2'(m);
         want = (m == 1) ? 1'b1 : 1'b0;
         push_byte(8'h07);
         wait_tx_start(ok);
         checks++; if (!ok) begin errors++; $display("FAIL txp%0d_start: got timeout want start bit", m); end
         repeat (8 + 16*9) @(negedge clk);
         checks++; if (tx_pin !== want) begin errors++; $display("FAIL txp%0d_parity: got %b want %b", m, tx_pin, want); end
         repeat (16) @(negedge clk);
         checks++; if (tx_pin !== 1'b1) begin errors++; $display("FAIL txp%0d_stop: got %b want 1", m, tx_pin); end
         repeat (7) @(negedge clk);
         checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL txp%0d_busy175: got %b want 1", m, tx_busy); end
         @(negedge clk);
         checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL txp%0d_busy176: got %b want 0", m, tx_busy); end
      end
      cfg_parity = 2'd0;
   endtask

   task automatic test_loopback();
      logic [7:0] exp_b [4];
      logic [7:0] got [4];
      int n;
      exp_b = '{8'h00, 8'h07, 8'hFF, 8'hA5};
      cfg_div = 16'd3; cfg_parity = 2'd1; cfg_stop2 = 1'b1; rx_ready = 1'b1; loop_en = 1'b1;
      for (int i = 0; i < 4; i++) push_byte(exp_b[i]);
      n = 0;
      for (int c = 0; c < 6000 && n < 4; c++) begin
         @(negedge clk);
         if (rx_valid) begin got[n] = rx_data; n++; end
      end
      checks++; if (n !== 4) begin errors++; $display("FAIL lb_count: got %0d want 4", n); end
      for (int i = 0; i < n; i++) begin
         checks++; if (got[i] !== exp_b[i]) begin errors++; $display("FAIL lb_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
      end
      checks++; if ({err_parity, err_frame, err_overrun} !== 3'b000) begin errors++;
         $display("FAIL lb_err: got %b want 000", {err_parity, err_frame, err_overrun}); end
      for (int c = 0; c < 2000 && tx_busy; c++) @(negedge clk);
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL lb_tx_idle: got %b want 0", tx_busy); end
      loop_en = 1'b0; cfg_div = 16'd0; cfg_parity = 2'd0; cfg_stop2 = 1'b0; rx_ready = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_frame_error();
      cfg_irq_en = 3'b100;
      send_frame(8'h3C, -1, 1'b0);
      checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin errors++;
         $display("FAIL fe_data: got v=%b d=%h want v=1 d=3c", rx_valid, rx_data); end
      checks++; if (err_frame !== 1'b1) begin errors++; $display("FAIL fe_flag: got %b want 1", err_frame); end
      checks++; if (err_parity !== 1'b0) begin errors++; $display("FAIL fe_parity: got %b want 0", err_parity); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL fe_irq: got %b want 1", irq); end
      pulse_clr();
      checks++; if (err_frame !== 1'b0) begin errors++; $display("FAIL fe_clr: got %b want 0", err_frame); end
      @(negedge clk);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL fe_irq_clr: got %b want 0", irq); end
      cfg_irq_en = 3'b001;
      @(negedge clk);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx_ne: got %b want 1", irq); end
      rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL fe_pop: got %b want 0", rx_valid); end
      @(negedge clk);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_rx_empty: got %b want 0", irq); end
      cfg_irq_en = 3'b000;
   endtask

   task automatic test_parity_error();
      cfg_parity = 2'd1;
      send_frame(8'h07, 0, 1'b1);
      checks++; if (err_parity !== 1'b1) begin errors++; $display("FAIL pe_flag: got %b want 1", err_parity); end
      checks++; if (err_frame !== 1'b0) begin errors++; $display("FAIL pe_frame: got %b want 0", err_frame); end
      checks++; if (rx_data !== 8'h07 || rx_count !== 5'd1) begin errors++;
         $display("FAIL pe_data: got d=%h n=%0d want 07 1", rx_data, rx_count); end
      rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
      pulse_clr();
      send_frame(8'h03, 0, 1'b1);
      checks++; if (err_parity !== 1'b0 || rx_data !== 8'h03) begin errors++;
         $display("FAIL pe_good: got e=%b d=%h want 0 03", err_parity, rx_data); end
      rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
      cfg_parity = 2'd0;
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 16; i++) send_frame(8'(8'h10 + i), -1, 1'b1);
      checks++; if (rx_count !== 5'd16) begin errors++; $display("FAIL ov_count16: got %0d want 16", rx_count); end
      checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL ov_early: got %b want 0", err_overrun); end
      send_frame(8'hEE, -1, 1'b1);
      checks++; if (rx_count !== 5'd16) begin errors++; $display("FAIL ov_count17: got %0d want 16", rx_count); end
      checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL ov_flag: got %b want 1", err_overrun); end
      checks++; if (rx_data !== 8'h10) begin errors++; $display("FAIL ov_head: got %h want 10", rx_data); end
      rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
      checks++; if (rx_data !== 8'h11 || rx_count !== 5'd15) begin errors++;
         $display("FAIL ov_pop: got d=%h n=%0d want 11 15", rx_data, rx_count); end
      rx_ready = 1'b1; repeat (15) @(negedge clk); rx_ready = 1'b0;
      checks++; if (rx_count !== 5'd0) begin errors++; $display("FAIL ov_drain: got %0d want 0", rx_count); end
      pulse_clr();
      checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL ov_clr: got %b want 0", err_overrun); end
   endtask

   task automatic test_glitch();
      @(negedge clk); rx_drv = 1'b0;
      repeat (4) @(negedge clk);
      rx_drv = 1'b1;
      repeat (40) @(negedge clk);
      checks++; if (rx_count !== 5'd0) begin errors++; $display("FAIL gl_nopush: got %0d want 0", rx_count); end
      checks++; if ({err_parity, err_frame, err_overrun} !== 3'b000) begin errors++;
         $display("FAIL gl_err: got %b want 000", {err_parity, err_frame, err_overrun}); end
      send_frame(8'h96, -1, 1'b1);
      checks++; if (rx_count !== 5'd1 || rx_data !== 8'h96) begin errors++;
         $display("FAIL gl_next: got n=%0d d=%h want 1 96", rx_count, rx_data); end
      rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      int lows;
      push_byte(8'h00); push_byte(8'h00); push_byte(8'h00);
      wait_tx_start(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rm_start: got timeout want start bit"); end
      repeat (40) @(negedge clk);
      checks++; if (tx_pin !== 1'b0) begin errors++; $display("FAIL rm_pre: got %b want 0", tx_pin); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (tx_pin !== 1'b1) begin errors++; $display("FAIL rm_pin: got %b want 1", tx_pin); end
      checks++; if (tx_count !== 5'd0) begin errors++; $display("FAIL rm_count: got %0d want 0", tx_count); end
      checks++; if (tx_ready !== 1'b1 || tx_busy !== 1'b0) begin errors++;
         $display("FAIL rm_state: got rdy=%b busy=%b want 1 0", tx_ready, tx_busy); end
      reset = 1'b0;
      lows = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (tx_pin == 1'b0) lows++;
      end
      checks++; if (lows !== 0) begin errors++; $display("FAIL rm_residual: got %0d low cycles want 0", lows); end
   endtask

   initial begin
      test_reset();
      test_tx_fifo_full();
      test_tx_frame();
      test_tx_parity();
      test_loopback();
      test_frame_error();
      test_parity_error();
      test_overrun();
      test_glitch();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
